// File: rtl/matrix_seq_ctrl_pkg.sv
// Shared types and constants for the systolic matrix-vector sequencing controller.
package matrix_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_CAL,
    ST_READ,
    ST_DONE
  } ctrl_state_t;

  localparam logic [1:0] CFG_ROW  = 2'd0;
  localparam logic [1:0] CFG_COL  = 2'd1;
  localparam logic [1:0] CFG_CTRL = 2'd2;

  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_ABORT = 1;

endpackage

// File: rtl/matrix_seq_ctrl_if.sv
// Config write port and result read-address port of the sequencing controller.
interface matrix_seq_ctrl_if #(
  parameter int unsigned BUS_W     = 32,
  parameter int unsigned ADDR_SIZE = 8
) ();

  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [1:0]           cfg_sel;
  logic [BUS_W-1:0]     cfg_data;
  logic                 rd_valid;
  logic                 rd_ready;
  logic [ADDR_SIZE-1:0] rd_addr;

  modport master (
    output cfg_valid, cfg_sel, cfg_data, rd_ready,
    input  cfg_ready, rd_valid, rd_addr
  );

  modport slave (
    input  cfg_valid, cfg_sel, cfg_data, rd_ready,
    output cfg_ready, rd_valid, rd_addr
  );

endinterface

// File: rtl/matrix_seq_ctrl_skew.sv
// Combinational systolic skew: PE i works on element cal_cnt-i while that lies in [0, row_size).
module matrix_skew_gen #(
  parameter int unsigned PE_NUMBER = 4,
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned DIM_W     = 8
) (
  input  logic                 en,
  input  logic [DIM_W:0]       cal_cnt,
  input  logic [DIM_W-1:0]     row_size,
  output logic [PE_NUMBER-1:0] pe_act,
  output logic [ADDR_SIZE-1:0] pe_addr [PE_NUMBER]
);

  // One extra bit so that cal_cnt < i shows up as a set sign bit.
  localparam int unsigned CW = DIM_W + 2;

  for (genvar i = 0; i < PE_NUMBER; i++) begin : g_pe
    logic [CW-1:0] diff;
    assign diff       = CW'(cal_cnt) - CW'(i);
    assign pe_act[i]  = en && !diff[CW-1] && (diff < CW'(row_size));
    assign pe_addr[i] = pe_act[i] ? ADDR_SIZE'(diff) : '0;
  end

endmodule

// File: rtl/matrix_seq_ctrl.sv
// Sequencing controller: clear, skewed compute phase, backpressured result read-out.
module matrix_seq_ctrl
  import matrix_pkg::*;
#(
  parameter int unsigned PE_NUMBER = 4,
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned DIM_W     = 8,
  parameter int unsigned BUS_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  matrix_seq_ctrl_if.slave     bus,
  output logic                 pe_clear,
  output logic [PE_NUMBER-1:0] pe_act,
  output logic [ADDR_SIZE-1:0] pe_addr [PE_NUMBER],
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int unsigned CW = DIM_W + 1;

  ctrl_state_t      state, state_next;
  logic [DIM_W-1:0] row_reg, row_next, col_reg, col_next;
  logic [DIM_W-1:0] row_sh, row_sh_next, col_sh, col_sh_next;
  logic [CW-1:0]    cal_cnt, cal_cnt_next, cal_last;
  logic [DIM_W-1:0] rd_cnt, rd_cnt_next;
  logic [BUS_W-1:0] cfg_word;
  logic             cfg_unused;
  logic             err_next, cfg_fire, rd_fire;

  assign cfg_word   = bus.cfg_data;
  assign cfg_unused = ^cfg_word;
  assign cfg_fire   = bus.cfg_valid && bus.cfg_ready;
  assign rd_fire    = bus.rd_valid && bus.rd_ready;
  assign cal_last   = CW'(row_sh) + CW'(col_sh) - CW'(2);

  // Next-state, register and counter update
  always_comb begin
    state_next   = state;
    row_next     = row_reg;
    col_next     = col_reg;
    row_sh_next  = row_sh;
    col_sh_next  = col_sh;
    cal_cnt_next = cal_cnt;
    rd_cnt_next  = rd_cnt;
    err_next     = err;
    unique case (state)
      ST_IDLE: begin
        if (cfg_fire) begin
          case (bus.cfg_sel)
            CFG_ROW: row_next = cfg_word[DIM_W-1:0];
            CFG_COL: col_next = cfg_word[DIM_W-1:0];
            CFG_CTRL: begin
              // Abort outranks start; in IDLE it simply swallows the write.
              if (!cfg_word[CTRL_ABORT] && cfg_word[CTRL_START]) begin
                if (row_reg == '0 || col_reg == '0) begin
                  err_next = 1'b1;
                end else begin
                  err_next    = 1'b0;
                  row_sh_next = row_reg;
                  col_sh_next = col_reg;
                  state_next  = ST_CLEAR;
                end
              end
            end
            default: ;
          endcase
        end
      end
      ST_CLEAR: begin
        cal_cnt_next = '0;
        state_next   = ST_CAL;
      end
      ST_CAL: begin
        if (cal_cnt == cal_last) begin
          rd_cnt_next = '0;
          state_next  = ST_READ;
        end else begin
          cal_cnt_next = cal_cnt + CW'(1);
        end
      end
      ST_READ: begin
        if (rd_fire) begin
          if (rd_cnt == col_sh - DIM_W'(1)) state_next = ST_DONE;
          else                              rd_cnt_next = rd_cnt + DIM_W'(1);
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      row_reg       <= '0;
      col_reg       <= '0;
      row_sh        <= '0;
      col_sh        <= '0;
      cal_cnt       <= '0;
      rd_cnt        <= '0;
      err           <= 1'b0;
      bus.cfg_ready <= 1'b0;
      bus.rd_valid  <= 1'b0;
      pe_clear      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_next;
      row_reg       <= row_next;
      col_reg       <= col_next;
      row_sh        <= row_sh_next;
      col_sh        <= col_sh_next;
      cal_cnt       <= cal_cnt_next;
      rd_cnt        <= rd_cnt_next;
      err           <= err_next;
      bus.cfg_ready <= (state_next == ST_IDLE);
      bus.rd_valid  <= (state_next == ST_READ);
      pe_clear      <= (state_next == ST_CLEAR);
      busy          <= (state_next != ST_IDLE);
      done          <= (state_next == ST_DONE);
    end
  end

  assign bus.rd_addr = (state == ST_READ) ? ADDR_SIZE'(rd_cnt) : '0;

  matrix_skew_gen #(
    .PE_NUMBER (PE_NUMBER),
    .ADDR_SIZE (ADDR_SIZE),
    .DIM_W     (DIM_W)
  ) u_skew (
    .en       (state == ST_CAL),
    .cal_cnt  (cal_cnt),
    .row_size (row_sh),
    .pe_act   (pe_act),
    .pe_addr  (pe_addr)
  );

endmodule

// File: tb/tb_matrix_seq_ctrl.sv
// Randomised self-checking bench for matrix_seq_ctrl against a cycle-level reference of the run timeline.
module tb_matrix_seq_ctrl;
  import matrix_pkg::*;

  localparam int unsigned PE_NUMBER = 4;
  localparam int unsigned ADDR_SIZE = 8;
  localparam int unsigned DIM_W     = 8;
  localparam int unsigned BUS_W     = 32;
  localparam int          AMASK     = (1 << ADDR_SIZE) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 pe_clear, busy, done, err;
  logic [PE_NUMBER-1:0] pe_act;
  logic [ADDR_SIZE-1:0] pe_addr [PE_NUMBER];

  matrix_seq_ctrl_if #(.BUS_W(BUS_W), .ADDR_SIZE(ADDR_SIZE)) bus ();

  matrix_seq_ctrl #(
    .PE_NUMBER (PE_NUMBER),
    .ADDR_SIZE (ADDR_SIZE),
    .DIM_W     (DIM_W),
    .BUS_W     (BUS_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .pe_clear (pe_clear),
    .pe_act   (pe_act),
    .pe_addr  (pe_addr),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  int   m_row = 0;
  int   m_col = 0;
  logic m_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a falling edge; returns at the falling edge just after the accepting rising edge.
  task automatic cfg_write(input logic [1:0] sel, input logic [31:0] data);
    int   n;
    logic acc;
    n = 0;
    bus.cfg_valid = 1'b1;
    bus.cfg_sel   = sel;
    bus.cfg_data  = data;
    forever begin
      acc = bus.cfg_ready;
      @(negedge clk);
      if (acc) break;
      n++;
      if (n > 3000) begin
        check("cfg_accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    bus.cfg_valid = 1'b0;
    if (acc && sel == CFG_ROW) m_row = int'(data[DIM_W-1:0]);
    if (acc && sel == CFG_COL) m_col = int'(data[DIM_W-1:0]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cfg_ready"}, 32'(bus.cfg_ready), 32'd0);
    check({tag, "_pe_clear"},  32'(pe_clear), 32'd0);
    check({tag, "_pe_act"},    32'(pe_act), 32'd0);
    check({tag, "_rd_valid"},  32'(bus.rd_valid), 32'd0);
    check({tag, "_rd_addr"},   32'(bus.rd_addr), 32'd0);
    check({tag, "_busy"},      32'(busy), 32'd0);
    check({tag, "_done"},      32'(done), 32'd0);
    check({tag, "_err"},       32'(err), 32'd0);
    for (int i = 0; i < PE_NUMBER; i++) check({tag, "_pe_addr"}, 32'(pe_addr[i]), 32'd0);
  endtask

  // mode: 0 rd_ready high, 1 random rd_ready, 2 three-cycle stall on read address 1.
  task automatic run_check(input int r, input int c, input int mode,
                           input bit pend_en, input logic [1:0] pend_sel, input logic [31:0] pend_data);
    logic [PE_NUMBER-1:0] exp_act;
    int hs, cyc, stall;
    bit rdy;
    check("clear_pulse", 32'(pe_clear), 32'd1);
    check("clear_busy",  32'(busy), 32'd1);
    check("clear_err",   32'(err), 32'd0);
    check("clear_ready", 32'(bus.cfg_ready), 32'd0);
    check("clear_act",   32'(pe_act), 32'd0);
    for (int t = 0; t < r + c - 1; t++) begin
      @(negedge clk);
      check("cal_clear",    32'(pe_clear), 32'd0);
      check("cal_rd_valid", 32'(bus.rd_valid), 32'd0);
      check("cal_busy",     32'(busy), 32'd1);
      exp_act = '0;
      for (int i = 0; i < PE_NUMBER; i++) begin
        int d;
        bit a;
        d = t - i;
        a = (d >= 0) && (d < r);
        exp_act[i] = a;
        check("cal_pe_addr", 32'(pe_addr[i]), a ? 32'(d & AMASK) : 32'd0);
      end
      check("cal_pe_act", 32'(pe_act), 32'(exp_act));
      if (pend_en) check("cal_ready_held", 32'(bus.cfg_ready), 32'd0);
      if (pend_en && t == 0) begin
        bus.cfg_valid = 1'b1;
        bus.cfg_sel   = pend_sel;
        bus.cfg_data  = pend_data;
      end
    end
    hs = 0;
    cyc = 0;
    stall = 0;
    while (hs < c && cyc < 4000) begin
      @(negedge clk);
      check("rd_valid",  32'(bus.rd_valid), 32'd1);
      check("rd_addr",   32'(bus.rd_addr), 32'(hs & AMASK));
      check("read_done", 32'(done), 32'd0);
      check("read_act",  32'(pe_act), 32'd0);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = !(hs == 1 && stall < 3);
      endcase
      if (!rdy) stall++;
      bus.rd_ready = rdy;
      if (rdy) hs++;
      cyc++;
    end
    if (hs < c) check("read_timeout", 32'd0, 32'd1);
    if (mode != 1) check("read_cycles", 32'(cyc), 32'(c + ((mode == 2 && c > 1) ? 3 : 0)));
    @(negedge clk);
    bus.rd_ready = 1'b1;
    check("done_pulse",    32'(done), 32'd1);
    check("done_busy",     32'(busy), 32'd1);
    check("done_rd_valid", 32'(bus.rd_valid), 32'd0);
    @(negedge clk);
    check("idle_done",  32'(done), 32'd0);
    check("idle_busy",  32'(busy), 32'd0);
    check("idle_ready", 32'(bus.cfg_ready), 32'd1);
    check("idle_err",   32'(err), 32'd0);
    if (pend_en) begin
      @(negedge clk);
      bus.cfg_valid = 1'b0;
      if (pend_sel == CFG_ROW) m_row = int'(pend_data[DIM_W-1:0]);
      if (pend_sel == CFG_COL) m_col = int'(pend_data[DIM_W-1:0]);
      check("pend_no_start", 32'(busy), 32'd0);
    end
  endtask

  task automatic do_start(input int mode, input bit pend_en, input logic [1:0] pend_sel,
                          input logic [31:0] pend_data);
    cfg_write(CFG_CTRL, 32'd1);
    if (m_row == 0 || m_col == 0) begin
      m_err = 1'b1;
      check("zero_err",   32'(err), 32'(m_err));
      check("zero_busy",  32'(busy), 32'd0);
      check("zero_clear", 32'(pe_clear), 32'd0);
      check("zero_ready", 32'(bus.cfg_ready), 32'd1);
    end else begin
      m_err = 1'b0;
      run_check(m_row, m_col, mode, pend_en, pend_sel, pend_data);
    end
  endtask

  task automatic sized_run(input int r, input int c, input int mode);
    cfg_write(CFG_ROW, 32'(r));
    cfg_write(CFG_COL, 32'(c));
    do_start(mode, 1'b0, CFG_ROW, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cfg_valid = 1'b0;
    bus.cfg_sel   = 2'd0;
    bus.cfg_data  = '0;
    bus.rd_ready  = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(bus.cfg_ready), 32'd1);

    sized_run(3, 2, 0);

    // Zero row size rejects the start, a later valid start clears err
    cfg_write(CFG_ROW, 32'd0);
    cfg_write(CFG_COL, 32'd5);
    do_start(0, 1'b0, CFG_ROW, 32'd0);
    @(negedge clk);
    check("err_sticky", 32'(err), 32'd1);
    check("err_idle",   32'(busy), 32'd0);
    cfg_write(CFG_ROW, 32'd2);
    do_start(1, 1'b0, CFG_ROW, 32'd0);

    // Abort together with start in IDLE does nothing
    cfg_write(CFG_CTRL, 32'd3);
    check("abort_busy",  32'(busy), 32'd0);
    check("abort_clear", 32'(pe_clear), 32'd0);
    check("abort_err",   32'(err), 32'd0);

    sized_run(2, 2, 2);

    // Column write during CAL is held off and applies to the next run
    cfg_write(CFG_ROW, 32'd2);
    cfg_write(CFG_COL, 32'd3);
    do_start(0, 1'b1, CFG_COL, 32'h0000_ff04);
    check("pend_col_model", 32'(m_col), 32'd4);
    do_start(0, 1'b0, CFG_ROW, 32'd0);

    sized_run(1, 1, 0);

    // Asynchronous reset in the middle of CAL
    cfg_write(CFG_ROW, 32'd3);
    cfg_write(CFG_COL, 32'd3);
    cfg_write(CFG_CTRL, 32'd1);
    repeat (3) @(negedge clk);
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    m_row = 0;
    m_col = 0;
    m_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_mid_reset", 32'(bus.cfg_ready), 32'd1);
    do_start(0, 1'b0, CFG_ROW, 32'd0);
    sized_run(2, 2, 0);

    for (int k = 0; k < 8; k++) begin
      sized_run(int'($urandom_range(1, 7)), int'($urandom_range(1, 7)), int'($urandom_range(0, 2)));
    end

    sized_run(255, 255, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
